// File: rtl/exp2_cla4_pkg.sv
// Shared constants for the exp2_cla4 carry-lookahead adder.
// Operand widths are built from 4-bit lookahead groups.
package exp2_cla4_pkg;

    localparam int GROUP = 4;

    // True when w is a positive whole number of lookahead groups
    function automatic bit width_ok(int w);
        return (w > 0) && ((w % GROUP) == 0);
    endfunction

endpackage

// File: rtl/cla4_group.sv
// One 4-bit carry-lookahead group: flat two-level carries,
// sum bits, and group propagate/generate for the next level.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] sum,
    output logic       c4,
    output logic       gp,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a direct sum of products; none reuses a lower carry
    assign c1 = g[0]
              | (p[0] & c0);

    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c0);

    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);

    assign c4 = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

    // Group terms do not depend on c0, so the second level sees no loop
    assign gp = &p;

    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

    assign sum = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/exp2_cla4.sv
// Registered carry-lookahead adder: {C4, F} = A + B + C0,
// built from 4-bit groups with a second-level group lookahead.
module exp2_cla4
    import exp2_cla4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic [WIDTH-1:0] F,
    output logic             C4
);

    localparam int NG = WIDTH / GROUP;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("exp2_cla4: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gc4;
    logic [NG:0]      gc;
    logic             acc;
    logic             term;
    logic             unused_gc4;

    genvar i;
    generate
        for (i = 0; i < NG; i++) begin : g_grp
            cla4_group u_grp (
                .a   (A[GROUP*i +: GROUP]),
                .b   (B[GROUP*i +: GROUP]),
                .c0  (gc[i]),
                .sum (sum[GROUP*i +: GROUP]),
                .c4  (gc4[i]),
                .gp  (gp[i]),
                .gg  (gg[i])
            );
        end
    endgenerate

    // The carry-out comes from the group lookahead; per-group c4
    // duplicates it and is left for reference only
    assign unused_gc4 = ^gc4;

    // Second-level lookahead: each group carry-in is a flat sum of
    // products over group generate/propagate and C0
    always_comb begin
        gc    = '0;
        acc   = 1'b0;
        term  = 1'b0;
        gc[0] = C0;
        for (int k = 0; k < NG; k++) begin
            term = C0;
            for (int m = 0; m <= k; m++) begin
                term = term & gp[m];
            end
            acc = term;
            for (int j = 0; j <= k; j++) begin
                term = gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & gp[m];
                end
                acc = acc | term;
            end
            gc[k+1] = acc;
        end
    end

    // Capture the sum and carry-out; reset clears both
    always_ff @(posedge clk) begin
        if (rst) begin
            F  <= '0;
            C4 <= 1'b0;
        end else begin
            F  <= sum;
            C4 <= gc[NG];
        end
    end

endmodule

// File: tb/tb_exp2_cla4.sv
// Directed and sweep bench for exp2_cla4 at WIDTH 4 and WIDTH 8.
// Outputs are sampled away from the rising edge.
module tb_exp2_cla4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c0;
    logic [3:0] f;
    logic       c4;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c08;
    logic [7:0] f8;
    logic       c48;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    exp2_cla4 #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .B   (b),
        .C0  (c0),
        .F   (f),
        .C4  (c4)
    );

    exp2_cla4 #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .A   (a8),
        .B   (b8),
        .C0  (c08),
        .F   (f8),
        .C4  (c48)
    );

    task automatic test_reset;
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        c0  = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            total++;
            if ({c4, f} !== 5'h00)
                $display("FAIL reset_hold[%0d] got=%h exp=00", n, {c4, f});
            else
                pass_cnt++;
            total++;
            if ({c48, f8} !== 9'h000)
                $display("FAIL reset_hold8[%0d] got=%h exp=000", n, {c48, f8});
            else
                pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({c4, f} !== 5'h1F)
            $display("FAIL reset_release got=%h exp=1f", {c4, f});
        else
            pass_cnt++;
    endtask

    task automatic test_directed;
        logic [3:0] ta [8] = '{4'h1, 4'h3, 4'h7, 4'h5, 4'hF, 4'h0, 4'h8, 4'hF};
        logic [3:0] tb [8] = '{4'h7, 4'hC, 4'hC, 4'h3, 4'h0, 4'h0, 4'h8, 4'hF};
        logic       tc [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [4:0] te [8] = '{5'h08, 5'h0F, 5'h14, 5'h09, 5'h10, 5'h00, 5'h10, 5'h1F};
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            a  = ta[n];
            b  = tb[n];
            c0 = tc[n];
            @(posedge clk);
            #1;
            total++;
            if ({c4, f} !== te[n])
                $display("FAIL directed[%0d] got=%h exp=%h", n, {c4, f}, te[n]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_hold;
        @(negedge clk);
        a  = 4'h6;
        b  = 4'h5;
        c0 = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        a  = 4'hF;
        b  = 4'hF;
        c0 = 1'b1;
        #2;
        total++;
        if ({c4, f} !== 5'h0B)
            $display("FAIL hold got=%h exp=0b", {c4, f});
        else
            pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if ({c4, f} !== 5'h1F)
            $display("FAIL hold_next got=%h exp=1f", {c4, f});
        else
            pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int         v    = 0;
        bit         have = 1'b0;
        bit         did  = 1'b0;
        logic [4:0] expq = '0;
        logic [8:0] vec;
        while (v < 512 || have) begin
            @(negedge clk);
            if (have) begin
                total++;
                if ({c4, f} !== expq)
                    $display("FAIL sweep[%0d] got=%h exp=%h", v, {c4, f}, expq);
                else
                    pass_cnt++;
            end
            if (v == 256 && !did) begin
                rst  = 1'b1;
                expq = 5'h00;
                have = 1'b1;
                did  = 1'b1;
            end else begin
                rst = 1'b0;
                if (v < 512) begin
                    vec        = v[8:0];
                    {a, b, c0} = vec;
                    expq = {1'b0, a} + {1'b0, b} + {4'b0, c0};
                    have = 1'b1;
                    v++;
                end else begin
                    have = 1'b0;
                end
            end
        end
    endtask

    task automatic test_wide;
        logic [7:0] ta [6] = '{8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h00, 8'h7F};
        logic [7:0] tb [6] = '{8'hFF, 8'h00, 8'h01, 8'h10, 8'h00, 8'h80};
        logic       tc [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [8:0] te [6] = '{9'h1FF, 9'h100, 9'h010, 9'h100, 9'h000, 9'h100};
        int         v    = 0;
        bit         have = 1'b0;
        logic [8:0] expq = '0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            a8  = ta[n];
            b8  = tb[n];
            c08 = tc[n];
            @(posedge clk);
            #1;
            total++;
            if ({c48, f8} !== te[n])
                $display("FAIL wide[%0d] got=%h exp=%h", n, {c48, f8}, te[n]);
            else
                pass_cnt++;
        end
        while (v < 300 || have) begin
            @(negedge clk);
            if (have) begin
                total++;
                if ({c48, f8} !== expq)
                    $display("FAIL wide_rand[%0d] got=%h exp=%h", v, {c48, f8}, expq);
                else
                    pass_cnt++;
            end
            if (v < 300) begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                c08  = 1'($urandom);
                expq = {1'b0, a8} + {1'b0, b8} + {8'b0, c08};
                have = 1'b1;
                v++;
            end else begin
                have = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        c0  = 1'b0;
        a8  = '0;
        b8  = '0;
        c08 = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
